reg_file_param: RTL and testbench

Parametrised successor to the CPU's 8 x 8 register file: DATA_W-bit registers, 2**ADDR_W entries, two combinational read ports and one clocked write port. Adds an optional hard-wired zero register. Adds a software-triggered clear sweep that zeroes one entry per cycle under a BUSY handshake, and an optional write-to-read bypass. It sits between the decode stage (read addresses) and the ALU/writeback path.

---
 rtl/reg_file_pkg.sv | 9 +
 rtl/reg_file_sweep_ctrl.sv | 58 +++++
 rtl/reg_file_param.sv | 70 +++++++
 tb/tb_reg_file_param.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and default dimensions for the parametrised register file.
package reg_file_pkg;

   typedef enum logic {IDLE, SWEEP} state_t;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 3;

endpackage

// File: rtl/reg_file_sweep_ctrl.sv
// Clear-sweep controller: walks a pointer over every entry, one per cycle, and
// owns the BUSY / CLEAR_DONE / WRITE_ERR handshake outputs.
module reg_file_sweep_ctrl
   import reg_file_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              WRITE,
   input  logic              CLEAR_REQ,
   output logic              BUSY,
   output logic              CLEAR_DONE,
   output logic              WRITE_ERR,
   output logic              sweep_we,
   output logic [ADDR_W-1:0] sweep_addr
);

   state_t            state;
   logic [ADDR_W-1:0] ptr;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= IDLE;
         ptr        <= '0;
         BUSY       <= 1'b0;
         CLEAR_DONE <= 1'b0;
         WRITE_ERR  <= 1'b0;
      end else begin
         CLEAR_DONE <= 1'b0;
         WRITE_ERR  <= 1'b0;
         case (state)
            IDLE: begin
               if (CLEAR_REQ) begin
                  state <= SWEEP;
                  ptr   <= '0;
                  BUSY  <= 1'b1;
               end
            end
            SWEEP: begin
               WRITE_ERR <= WRITE;
               ptr       <= ptr + 1'b1;
               // Pointer at the last entry: this edge finishes the sweep and ptr wraps to 0.
               if (ptr == '1) begin
                  state      <= IDLE;
                  BUSY       <= 1'b0;
                  CLEAR_DONE <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign sweep_we   = (state == SWEEP);
   assign sweep_addr = ptr;

endmodule

// File: rtl/reg_file_param.sv
// Parametrised 2-read / 1-write register file with clear sweep and optional zero
// register. Define REGFILE_BYPASS_EN for write-first read bypass in IDLE.
module reg_file_param
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int ZERO_REG = 0
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              WRITE,
   input  logic [ADDR_W-1:0] INADDRESS,
   input  logic [DATA_W-1:0] IN,
   input  logic [ADDR_W-1:0] OUT1ADDRESS,
   output logic [DATA_W-1:0] OUT1,
   input  logic [ADDR_W-1:0] OUT2ADDRESS,
   output logic [DATA_W-1:0] OUT2,
   input  logic              CLEAR_REQ,
   output logic              BUSY,
   output logic              CLEAR_DONE,
   output logic              WRITE_ERR
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam bit ZR    = (ZERO_REG != 0);

   logic [DATA_W-1:0] mem [DEPTH];
   logic              sweep_we;
   logic [ADDR_W-1:0] sweep_addr;
   logic              user_we;

   reg_file_sweep_ctrl #(.ADDR_W(ADDR_W)) u_ctrl (
      .CLK        (CLK),
      .RESET      (RESET),
      .WRITE      (WRITE),
      .CLEAR_REQ  (CLEAR_REQ),
      .BUSY       (BUSY),
      .CLEAR_DONE (CLEAR_DONE),
      .WRITE_ERR  (WRITE_ERR),
      .sweep_we   (sweep_we),
      .sweep_addr (sweep_addr)
   );

   // User writes only land in IDLE; entry 0 is read-only when it is the zero register.
   assign user_we = WRITE && !sweep_we && !(ZR && INADDRESS == '0);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (sweep_we) begin
         mem[sweep_addr] <= '0;
      end else if (user_we) begin
         mem[INADDRESS] <= IN;
      end
   end

   always_comb begin
      OUT1 = mem[OUT1ADDRESS];
      OUT2 = mem[OUT2ADDRESS];
`ifdef REGFILE_BYPASS_EN
      if (user_we && OUT1ADDRESS == INADDRESS) OUT1 = IN;
      if (user_we && OUT2ADDRESS == INADDRESS) OUT2 = IN;
`endif
      // Zero register overrides both storage and bypass.
      if (ZR && OUT1ADDRESS == '0) OUT1 = '0;
      if (ZR && OUT2ADDRESS == '0) OUT2 = '0;
   end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: one instance with ZERO_REG=0, one with ZERO_REG=1.
module tb_reg_file_param;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       WRITE;
   logic [2:0] INADDRESS;
   logic [7:0] IN;
   logic [2:0] OUT1ADDRESS;
   logic [7:0] OUT1;
   logic [2:0] OUT2ADDRESS;
   logic [7:0] OUT2;
   logic       CLEAR_REQ;
   logic       BUSY;
   logic       CLEAR_DONE;
   logic       WRITE_ERR;

   logic [7:0] z_out1, z_out2;
   logic       z_busy, z_done, z_err;

   int total = 0;
   int passed = 0;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   always #5 CLK = ~CLK;

   reg_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0)) dut (
      .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
      .OUT1ADDRESS(OUT1ADDRESS), .OUT1(OUT1), .OUT2ADDRESS(OUT2ADDRESS), .OUT2(OUT2),
      .CLEAR_REQ(CLEAR_REQ), .BUSY(BUSY), .CLEAR_DONE(CLEAR_DONE), .WRITE_ERR(WRITE_ERR)
   );

   reg_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1)) dut_z (
      .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
      .OUT1ADDRESS(OUT1ADDRESS), .OUT1(z_out1), .OUT2ADDRESS(OUT2ADDRESS), .OUT2(z_out2),
      .CLEAR_REQ(CLEAR_REQ), .BUSY(z_busy), .CLEAR_DONE(z_done), .WRITE_ERR(z_err)
   );

   // Inputs change on the falling edge; outputs are sampled there too.
   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic fill_all();
      WRITE = 1'b1;
      for (int i = 0; i < 8; i++) begin
         INADDRESS = 3'(i);
         IN        = 8'(8'h11 * (i + 1));
         tick();
      end
      WRITE = 1'b0;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      tick();
      tick();
      RESET = 1'b0;
      for (int i = 0; i < 8; i++) begin
         OUT1ADDRESS = 3'(i);
         OUT2ADDRESS = 3'(7 - i);
         #1;
         total++;
         if (OUT1 !== 8'h00 || OUT2 !== 8'h00)
            $display("FAIL reset_read[%0d]: OUT1=%h OUT2=%h expected 00 00", i, OUT1, OUT2);
         else passed++;
      end
      total++;
      if (BUSY !== 1'b0 || CLEAR_DONE !== 1'b0 || WRITE_ERR !== 1'b0)
         $display("FAIL reset_ctrl: BUSY=%b DONE=%b ERR=%b expected 0 0 0", BUSY, CLEAR_DONE, WRITE_ERR);
      else passed++;
   endtask

   task automatic test_write_read();
      logic [7:0] exp1;
      WRITE       = 1'b1;
      INADDRESS   = 3'd3;
      IN          = 8'hA5;
      OUT1ADDRESS = 3'd3;
      OUT2ADDRESS = 3'd5;
      #1;
      exp1 = BYP ? 8'hA5 : 8'h00;
      total++;
      if (OUT1 !== exp1) $display("FAIL write_cycle_r3: OUT1=%h expected %h", OUT1, exp1);
      else passed++;
      tick();
      INADDRESS = 3'd5;
      IN        = 8'h3C;
      tick();
      WRITE = 1'b0;
      #1;
      total++;
      if (OUT1 !== 8'hA5 || OUT2 !== 8'h3C)
         $display("FAIL write_read: OUT1=%h OUT2=%h expected a5 3c", OUT1, OUT2);
      else passed++;
   endtask

   task automatic test_sweep();
      fill_all();
      OUT1ADDRESS = 3'd2;
      OUT2ADDRESS = 3'd7;
      #1;
      total++;
      if (OUT1 !== 8'h33 || OUT2 !== 8'h88)
         $display("FAIL fill: r2=%h r7=%h expected 33 88", OUT1, OUT2);
      else passed++;
      CLEAR_REQ = 1'b1;
      tick();
      CLEAR_REQ = 1'b0;
      for (int j = 1; j <= 8; j++) begin
         total++;
         if (BUSY !== 1'b1 || CLEAR_DONE !== 1'b0)
            $display("FAIL sweep_busy[%0d]: BUSY=%b DONE=%b expected 1 0", j, BUSY, CLEAR_DONE);
         else passed++;
         tick();
         if (j == 2) begin
            total++;
            if (OUT1 !== 8'h33) $display("FAIL sweep_r2_early: r2=%h expected 33", OUT1);
            else passed++;
         end
         if (j == 3) begin
            total++;
            if (OUT1 !== 8'h00 || OUT2 !== 8'h88)
               $display("FAIL sweep_mid: r2=%h r7=%h expected 00 88", OUT1, OUT2);
            else passed++;
         end
      end
      total++;
      if (BUSY !== 1'b0 || CLEAR_DONE !== 1'b1)
         $display("FAIL sweep_end: BUSY=%b DONE=%b expected 0 1", BUSY, CLEAR_DONE);
      else passed++;
      tick();
      total++;
      if (CLEAR_DONE !== 1'b0) $display("FAIL done_pulse: DONE=%b expected 0", CLEAR_DONE);
      else passed++;
      for (int i = 0; i < 8; i++) begin
         OUT1ADDRESS = 3'(i);
         #1;
         total++;
         if (OUT1 !== 8'h00) $display("FAIL swept[%0d]: %h expected 00", i, OUT1);
         else passed++;
      end
   endtask

   task automatic test_write_err();
      OUT1ADDRESS = 3'd1;
      CLEAR_REQ = 1'b1;
      tick();
      CLEAR_REQ = 1'b0;
      for (int j = 1; j <= 8; j++) begin
         if (j == 5) begin
            WRITE     = 1'b1;
            INADDRESS = 3'd1;
            IN        = 8'hFF;
            #1;
            total++;
            if (OUT1 !== 8'h00) $display("FAIL no_bypass_in_sweep: r1=%h expected 00", OUT1);
            else passed++;
         end
         tick();
         WRITE = 1'b0;
         if (j == 4 || j == 5 || j == 6) begin
            total++;
            if (WRITE_ERR !== (j == 5))
               $display("FAIL write_err[%0d]: ERR=%b expected %b", j, WRITE_ERR, (j == 5));
            else passed++;
         end
      end
      #1;
      total++;
      if (OUT1 !== 8'h00 || CLEAR_DONE !== 1'b1)
         $display("FAIL sweep_write_dropped: r1=%h DONE=%b expected 00 1", OUT1, CLEAR_DONE);
      else passed++;
      tick();
   endtask

   task automatic test_reset_mid_sweep();
      fill_all();
      CLEAR_REQ = 1'b1;
      tick();
      CLEAR_REQ = 1'b0;
      for (int j = 1; j <= 3; j++) tick();
      OUT1ADDRESS = 3'd6;
      #1;
      total++;
      if (OUT1 !== 8'h77 || BUSY !== 1'b1)
         $display("FAIL pre_abort: r6=%h BUSY=%b expected 77 1", OUT1, BUSY);
      else passed++;
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      for (int i = 0; i < 8; i++) begin
         OUT1ADDRESS = 3'(i);
         #1;
         total++;
         if (OUT1 !== 8'h00) $display("FAIL abort_clear[%0d]: %h expected 00", i, OUT1);
         else passed++;
      end
      for (int j = 0; j < 10; j++) begin
         total++;
         if (BUSY !== 1'b0 || CLEAR_DONE !== 1'b0)
            $display("FAIL abort_ctrl[%0d]: BUSY=%b DONE=%b expected 0 0", j, BUSY, CLEAR_DONE);
         else passed++;
         tick();
      end
   endtask

   task automatic test_back_to_back();
      CLEAR_REQ = 1'b1;
      for (int j = 0; j <= 8; j++) tick();
      total++;
      if (BUSY !== 1'b0 || CLEAR_DONE !== 1'b1)
         $display("FAIL b2b_first_end: BUSY=%b DONE=%b expected 0 1", BUSY, CLEAR_DONE);
      else passed++;
      tick();
      CLEAR_REQ = 1'b0;
      total++;
      if (BUSY !== 1'b1 || CLEAR_DONE !== 1'b0)
         $display("FAIL b2b_restart: BUSY=%b DONE=%b expected 1 0", BUSY, CLEAR_DONE);
      else passed++;
      for (int j = 0; j < 8; j++) tick();
      total++;
      if (BUSY !== 1'b0 || CLEAR_DONE !== 1'b1)
         $display("FAIL b2b_second_end: BUSY=%b DONE=%b expected 0 1", BUSY, CLEAR_DONE);
      else passed++;
      tick();
   endtask

   task automatic test_zero_reg();
      WRITE       = 1'b1;
      INADDRESS   = 3'd0;
      IN          = 8'h7E;
      OUT1ADDRESS = 3'd0;
      OUT2ADDRESS = 3'd0;
      #1;
      total++;
      if (z_out1 !== 8'h00 || z_out2 !== 8'h00)
         $display("FAIL zero_reg_write_cycle: OUT1=%h OUT2=%h expected 00 00", z_out1, z_out2);
      else passed++;
      tick();
      WRITE = 1'b0;
      #1;
      total++;
      if (z_out1 !== 8'h00) $display("FAIL zero_reg_after: OUT1=%h expected 00", z_out1);
      else passed++;
      total++;
      if (OUT1 !== 8'h7E) $display("FAIL r0_plain: OUT1=%h expected 7e", OUT1);
      else passed++;
      WRITE     = 1'b1;
      INADDRESS = 3'd4;
      IN        = 8'h5A;
      tick();
      WRITE       = 1'b0;
      OUT2ADDRESS = 3'd4;
      #1;
      total++;
      if (z_out2 !== 8'h5A) $display("FAIL zero_reg_r4: OUT2=%h expected 5a", z_out2);
      else passed++;
   endtask

   initial begin
      RESET       = 1'b1;
      WRITE       = 1'b0;
      INADDRESS   = '0;
      IN          = '0;
      OUT1ADDRESS = '0;
      OUT2ADDRESS = '0;
      CLEAR_REQ   = 1'b0;
      @(negedge CLK);
      test_reset();
      test_write_read();
      test_sweep();
      test_write_err();
      test_reset_mid_sweep();
      test_back_to_back();
      test_zero_reg();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
